// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a combinational unit through every input code,
// captures each output row and scores it against an expected table.
module truth_table_scanner #(
  parameter int N      = 3,
  parameter int M      = 3,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [N-1:0]          code,
  input  logic [M-1:0]          f_in,
  input  logic [M*(2**N)-1:0]   expected,
  output logic [M*(2**N)-1:0]   table_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N:0]            err_count,
  output logic [N-1:0]          first_err_code
);

  localparam int ROWS = 2 ** N;
  localparam int W    = M * ROWS;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [N-1:0]  CODE_LAST = {N{1'b1}};
  localparam logic [N:0]    ERR_ONE   = (N+1)'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  code_q, code_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [N:0]    err_q, err_d;
  logic [N-1:0]  first_q, first_d;
  logic [W-1:0]  table_q, table_d;
  logic [M-1:0]  row_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      table_q <= table_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    table_d = table_q;
    row_exp = expected[int'(code_q)*M +: M];
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          cnt_d   = '0;
          code_d  = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
          table_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          code_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // sample edge: capture row, score it, then advance or finish
          table_d[int'(code_q)*M +: M] = f_in;
          if (f_in != row_exp) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) first_d = code_q;
          end
          cnt_d = '0;
          if (code_q == CODE_LAST) begin
            state_d = IDLE;
            code_d  = '0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            code_d = code_q + N'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign code           = code_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_code = first_q;
  assign table_out      = table_q;

endmodule
